// File: rtl/imem_responder_if.sv
// imem_responder_if
//
// Bundles the fetch request/response handshake of the instruction memory
// responder, together with the optional DMA write port and the DMA busy flag.
// Signal names keep the responder-side _i/_o suffixes so that waveforms line
// up with the responder's documentation.
//
// Configuration macro: IMEM_DMA_PORT_EN adds dma_we_i/dma_addr_i/dma_wdata_i.
//
// Signals (direction as seen by the responder, modport slave):
//   req_valid_i  in   fetch request from the prefetch side
//   req_addr_i   in   fetch byte address (PC)
//   req_ready_o  out  request accepted when high together with req_valid_i
//   flush_i      in   branch/redirect, kills the in-flight request
//   rsp_valid_o  out  one-cycle response pulse
//   rsp_instr_o  out  fetched instruction (NOP on error)
//   rsp_pc_o     out  address of the request being answered
//   rsp_err_o    out  misaligned or out-of-range request
//   dma_we_i     in   DMA word write enable      (IMEM_DMA_PORT_EN only)
//   dma_addr_i   in   DMA write byte address     (IMEM_DMA_PORT_EN only)
//   dma_wdata_i  in   DMA write data             (IMEM_DMA_PORT_EN only)
//   dma_busy_o   out  DMA write happened in the previous cycle
interface imem_responder_if #(
    parameter int unsigned XLEN = 32
);
    logic            req_valid_i;
    logic [XLEN-1:0] req_addr_i;
    logic            req_ready_o;
    logic            flush_i;
    logic            rsp_valid_o;
    logic [31:0]     rsp_instr_o;
    logic [XLEN-1:0] rsp_pc_o;
    logic            rsp_err_o;
`ifdef IMEM_DMA_PORT_EN
    logic            dma_we_i;
    logic [XLEN-1:0] dma_addr_i;
    logic [31:0]     dma_wdata_i;
`endif
    logic            dma_busy_o;

    modport slave (
`ifdef IMEM_DMA_PORT_EN
        input  dma_we_i, dma_addr_i, dma_wdata_i,
`endif
        input  req_valid_i, req_addr_i, flush_i,
        output req_ready_o, rsp_valid_o, rsp_instr_o, rsp_pc_o, rsp_err_o, dma_busy_o
    );

    modport master (
`ifdef IMEM_DMA_PORT_EN
        output dma_we_i, dma_addr_i, dma_wdata_i,
`endif
        output req_valid_i, req_addr_i, flush_i,
        input  req_ready_o, rsp_valid_o, rsp_instr_o, rsp_pc_o, rsp_err_o, dma_busy_o
    );
endinterface

// File: rtl/imem_responder.sv
// imem_responder
//
// Single-outstanding instruction fetch responder in front of a word array.
// A request is accepted in IDLE, waits WAIT_STATES cycles and is answered
// with a one-cycle rsp_valid_o pulse. Misaligned or out-of-range addresses
// are answered with rsp_err_o and a NOP. A flush kills the in-flight request.
//
// Configuration macro: IMEM_DMA_PORT_EN
//   defined   : DMA word write port present, DMA writes have priority over
//               fetches (acceptance blocked, wait counter frozen)
//   undefined : array is read-only (loaded by the simulation environment),
//               dma_busy_o is tied low
//
// Ports:
//   clk_i   clock, all state on the rising edge
//   rst_ni  asynchronous active-low reset
//   bus     imem_responder_if.slave (request, response and DMA signals)
module imem_responder #(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     DEPTH_WORDS = 1024,
    parameter logic [XLEN-1:0] BASE_ADDR   = XLEN'(32'h1000_0000),
    parameter int unsigned     WAIT_STATES = 1
) (
    input logic             clk_i,
    input logic             rst_ni,
    imem_responder_if.slave bus
);
    localparam int unsigned AW  = $clog2(DEPTH_WORDS);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e          state_q;
    logic [2:0]      cnt_q;
    logic [XLEN-1:0] addr_q;
    logic [31:0]     rspInstr_q;
    logic [XLEN-1:0] rspPc_q;
    logic            rspErr_q;

    logic [31:0]     mem [DEPTH_WORDS];

    logic            dmaWe;
    logic            reqReady;
    logic            accept;
    logic            enterResp;
    logic [XLEN-1:0] fetchAddr;
    logic [XLEN-3:0] fetchWordOff;
    logic            fetchErr;
    logic [AW-1:0]   fetchIdx;

`ifdef IMEM_DMA_PORT_EN
    logic            dmaBusy_q;
    logic [XLEN-3:0] dmaWordOff;
    logic            dmaErr;

    assign dmaWe = bus.dma_we_i;
`else
    assign dmaWe = 1'b0;
`endif

    assign reqReady = (state_q == IDLE) && !bus.flush_i && !dmaWe;
    assign accept   = bus.req_valid_i && reqReady;

    // Address decode for the response being prepared. With zero wait states the
    // response is loaded straight from the incoming request, otherwise from the
    // latched address. The word offset is taken on the word-address bits, which
    // equals (addr - BASE_ADDR) >> 2 for a word-aligned base; anything above
    // the array index bits means out of range, including wrap-around below base.
    always_comb begin
        fetchAddr    = (state_q == IDLE) ? bus.req_addr_i : addr_q;
        fetchWordOff = fetchAddr[XLEN-1:2] - BASE_ADDR[XLEN-1:2];
        fetchErr     = (fetchAddr[1:0] != 2'b00) || (fetchWordOff[XLEN-3:AW] != '0);
        fetchIdx     = fetchWordOff[AW-1:0];
    end

    // The cycle that moves the FSM into RESP is also the cycle the response
    // registers are loaded, so they are stable for the whole RESP cycle. A DMA
    // write never lands on this edge because it freezes WAIT and blocks
    // acceptance, so reading here sees the same word as reading in RESP.
    always_comb begin
        enterResp = 1'b0;
        if (state_q == IDLE) begin
            enterResp = accept && (WAIT_STATES == 0);
        end else if (state_q == WAIT) begin
            enterResp = !bus.flush_i && !dmaWe && (cnt_q <= 3'd1);
        end
    end

    // Fetch FSM with the latched request and the held response fields.
    // The counter is loaded with WAIT_STATES and the last WAIT cycle is the one
    // seeing a count of one, which gives acceptance-to-response latency of
    // 1 + WAIT_STATES. Reset discards any request in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= BASE_ADDR;
            rspInstr_q <= NOP;
            rspPc_q    <= BASE_ADDR;
            rspErr_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_q <= bus.req_addr_i;
                        if (WAIT_STATES == 0) begin
                            state_q <= RESP;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= 3'(WAIT_STATES);
                        end
                    end
                end
                WAIT: begin
                    if (bus.flush_i) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (!dmaWe) begin
                        cnt_q <= cnt_q - 3'd1;
                        if (cnt_q <= 3'd1) begin
                            state_q <= RESP;
                        end
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            if (enterResp) begin
                rspPc_q    <= fetchAddr;
                rspErr_q   <= fetchErr;
                rspInstr_q <= fetchErr ? NOP : mem[fetchIdx];
            end
        end
    end

`ifdef IMEM_DMA_PORT_EN
    // DMA address decode mirrors the fetch decode; bad addresses are dropped.
    always_comb begin
        dmaWordOff = bus.dma_addr_i[XLEN-1:2] - BASE_ADDR[XLEN-1:2];
        dmaErr     = (bus.dma_addr_i[1:0] != 2'b00) || (dmaWordOff[XLEN-3:AW] != '0);
    end

    // Array write port; contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (bus.dma_we_i && !dmaErr) begin
            mem[dmaWordOff[AW-1:0]] <= bus.dma_wdata_i;
        end
    end

    // Busy flag trails the write by one cycle so the core can stall on it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dmaBusy_q <= 1'b0;
        end else begin
            dmaBusy_q <= bus.dma_we_i;
        end
    end

    assign bus.dma_busy_o = dmaBusy_q;
`else
    assign bus.dma_busy_o = 1'b0;
`endif

    // A flush in the RESP cycle suppresses the pulse so that request is never answered.
    assign bus.req_ready_o = reqReady;
    assign bus.rsp_valid_o = (state_q == RESP) && !bus.flush_i;
    assign bus.rsp_instr_o = rspInstr_q;
    assign bus.rsp_pc_o    = rspPc_q;
    assign bus.rsp_err_o   = rspErr_q;
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder
//
// Scoreboard bench for imem_responder. dutA runs with one wait state and
// carries the directed fetch, error, flush and reset scenarios; dutB runs with
// zero wait states and is driven with a held request stream. Expected
// responses, including the cycle they must appear in, are queued when a
// request is accepted and popped by per-DUT monitors on rsp_valid_o.
// Honours IMEM_DMA_PORT_EN: array preload goes through the DMA port when the
// macro is defined, and a DMA-during-WAIT scenario is added.
module tb_imem_responder;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        qA[$];
    exp_t        qB[$];
    exp_t        eA;
    exp_t        eB;
    int          accB[4];
    logic [31:0] instrB[4];

    imem_responder_if #(.XLEN(32)) ifA ();
    imem_responder_if #(.XLEN(32)) ifB ();

    imem_responder #(
        .XLEN(32), .DEPTH_WORDS(1024), .BASE_ADDR(BASE), .WAIT_STATES(1)
    ) dutA (
        .clk_i(clk), .rst_ni(rst_n), .bus(ifA)
    );

    imem_responder #(
        .XLEN(32), .DEPTH_WORDS(1024), .BASE_ADDR(BASE), .WAIT_STATES(0)
    ) dutB (
        .clk_i(clk), .rst_ni(rst_n), .bus(ifB)
    );

    // Free-running clock and a cycle counter used to timestamp responses.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Hard stop in case something wedges the stimulus process.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Monitor for dutA: every response pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (ifA.rsp_valid_o === 1'b1) begin
            if (qA.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL A unexpected response: got pc %h at cycle %0d required no response",
                         ifA.rsp_pc_o, cyc);
            end else begin
                eA = qA.pop_front();
                checkOutput("A rsp_instr", ifA.rsp_instr_o, eA.instr);
                checkOutput("A rsp_pc", ifA.rsp_pc_o, eA.pc);
                checkOutput("A rsp_err", 32'(ifA.rsp_err_o), 32'(eA.err));
                checkOutput("A rsp cycle", 32'(cyc), 32'(eA.cyc));
            end
        end
    end

    // Monitor for dutB, same rules.
    always @(negedge clk) begin
        if (ifB.rsp_valid_o === 1'b1) begin
            if (qB.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL B unexpected response: got pc %h at cycle %0d required no response",
                         ifB.rsp_pc_o, cyc);
            end else begin
                eB = qB.pop_front();
                checkOutput("B rsp_instr", ifB.rsp_instr_o, eB.instr);
                checkOutput("B rsp_pc", ifB.rsp_pc_o, eB.pc);
                checkOutput("B rsp_err", 32'(ifB.rsp_err_o), 32'(eB.err));
                checkOutput("B rsp cycle", 32'(cyc), 32'(eB.cyc));
            end
        end
    end

    // Puts one word into both arrays at the same index.
    task automatic loadWord(input int idx, input logic [31:0] data);
`ifdef IMEM_DMA_PORT_EN
        ifA.dma_we_i    = 1'b1;
        ifA.dma_addr_i  = BASE + (32'(idx) << 2);
        ifA.dma_wdata_i = data;
        ifB.dma_we_i    = 1'b1;
        ifB.dma_addr_i  = BASE + (32'(idx) << 2);
        ifB.dma_wdata_i = data;
        @(posedge clk);
        #1;
        ifA.dma_we_i = 1'b0;
        ifB.dma_we_i = 1'b0;
`else
        dutA.mem[idx[9:0]] = data;
        dutB.mem[idx[9:0]] = data;
`endif
    endtask

    // Issues one request to dutA and waits (bounded) for acceptance. A lat of
    // zero means the request is expected to be killed and never answered.
    // Returns one cycle after acceptance, #1 past the clock edge.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] instr,
                                 input logic err, input int lat);
        int tries;
        tries = 0;
        ifA.req_valid_i = 1'b1;
        ifA.req_addr_i  = addr;
        @(negedge clk);
        while (ifA.req_ready_o !== 1'b1 && tries < 20) begin
            tries++;
            @(negedge clk);
        end
        if (tries >= 20) begin
            checks++;
            errors++;
            $display("[TB] FAIL A accept timeout: got ready low for 20 cycles required acceptance of %h", addr);
        end else if (lat > 0) begin
            qA.push_back(exp_t'{instr, addr, err, cyc + lat});
        end
        @(posedge clk);
        #1;
        ifA.req_valid_i = 1'b0;
    endtask

    // Reset values must be visible on both DUTs while reset is held.
    task automatic checkResetState(input string tag);
        checkOutput({tag, " A rsp_valid"}, 32'(ifA.rsp_valid_o), 32'd0);
        checkOutput({tag, " A rsp_instr"}, ifA.rsp_instr_o, NOP);
        checkOutput({tag, " A rsp_pc"}, ifA.rsp_pc_o, BASE);
        checkOutput({tag, " A rsp_err"}, 32'(ifA.rsp_err_o), 32'd0);
        checkOutput({tag, " A dma_busy"}, 32'(ifA.dma_busy_o), 32'd0);
        checkOutput({tag, " B rsp_instr"}, ifB.rsp_instr_o, NOP);
        checkOutput({tag, " B rsp_pc"}, ifB.rsp_pc_o, BASE);
    endtask

    initial begin
        instrB[0] = 32'h0000_0297;
        instrB[1] = 32'h00A0_0093;
        instrB[2] = 32'h00B0_0113;
        instrB[3] = 32'h00C0_0193;

        rst_n           = 1'b0;
        ifA.req_valid_i = 1'b0;
        ifA.req_addr_i  = '0;
        ifA.flush_i     = 1'b0;
        ifB.req_valid_i = 1'b0;
        ifB.req_addr_i  = '0;
        ifB.flush_i     = 1'b0;
`ifdef IMEM_DMA_PORT_EN
        ifA.dma_we_i    = 1'b0;
        ifA.dma_addr_i  = '0;
        ifA.dma_wdata_i = '0;
        ifB.dma_we_i    = 1'b0;
        ifB.dma_addr_i  = '0;
        ifB.dma_wdata_i = '0;
`endif

        repeat (2) @(negedge clk);
        checkResetState("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int k = 0; k < 4; k++) loadWord(k, instrB[k]);
        loadWord(1023, 32'h1234_5678);
        @(posedge clk);
        #1;

        // Basic fetches, misaligned/below-base/above-top errors, last word.
        applyStimulus(BASE,           32'h0000_0297, 1'b0, 2);
        applyStimulus(32'h1000_0004,  32'h00A0_0093, 1'b0, 2);
        applyStimulus(32'h1000_0002,  NOP,           1'b1, 2);
        applyStimulus(32'h0FFF_FFFC,  NOP,           1'b1, 2);
        applyStimulus(32'h1000_1000,  NOP,           1'b1, 2);
        applyStimulus(32'h1000_0FFC,  32'h1234_5678, 1'b0, 2);

        // Response fields hold after the pulse.
        repeat (4) @(negedge clk);
        checkOutput("A hold rsp_instr", ifA.rsp_instr_o, 32'h1234_5678);
        checkOutput("A hold rsp_pc", ifA.rsp_pc_o, 32'h1000_0FFC);
        checkOutput("A hold rsp_err", 32'(ifA.rsp_err_o), 32'd0);
        @(posedge clk);
        #1;

        // Flush while waiting: request dies, ready returns the cycle after.
        applyStimulus(32'h1000_0004, 32'h0, 1'b0, 0);
        ifA.flush_i = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        ifA.flush_i = 1'b0;
        @(negedge clk);
        checkOutput("A ready after flush", 32'(ifA.req_ready_o), 32'd1);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;

        // Flush in IDLE blocks acceptance.
        ifA.req_valid_i = 1'b1;
        ifA.req_addr_i  = 32'h1000_0008;
        ifA.flush_i     = 1'b1;
        @(negedge clk);
        checkOutput("A ready under flush", 32'(ifA.req_ready_o), 32'd0);
        @(posedge clk);
        #1;
        ifA.req_valid_i = 1'b0;
        ifA.flush_i     = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;

        // Flush in the RESP cycle suppresses the pulse.
        applyStimulus(32'h1000_0008, 32'h0, 1'b0, 0);
        @(posedge clk);
        #1;
        ifA.flush_i = 1'b1;
        @(negedge clk);
        checkOutput("A rsp_valid under flush", 32'(ifA.rsp_valid_o), 32'd0);
        @(posedge clk);
        #1;
        ifA.flush_i = 1'b0;
        applyStimulus(32'h1000_0004, 32'h00A0_0093, 1'b0, 2);

`ifdef IMEM_DMA_PORT_EN
        // DMA write during WAIT freezes the counter for one cycle.
        applyStimulus(32'h1000_0008, 32'h00B0_0113, 1'b0, 3);
        ifA.dma_we_i    = 1'b1;
        ifA.dma_addr_i  = 32'h1000_0010;
        ifA.dma_wdata_i = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        ifA.dma_we_i = 1'b0;
        @(negedge clk);
        checkOutput("A dma_busy after write", 32'(ifA.dma_busy_o), 32'd1);
        @(posedge clk);
        #1;
        applyStimulus(32'h1000_0010, 32'hDEAD_BEEF, 1'b0, 2);
`endif

        // Zero-wait-state stream with valid held high.
        ifB.req_valid_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            int tries;
            tries = 0;
            ifB.req_addr_i = BASE + (32'(k) << 2);
            @(negedge clk);
            while (ifB.req_ready_o !== 1'b1 && tries < 10) begin
                tries++;
                @(negedge clk);
            end
            if (tries >= 10) begin
                checks++;
                errors++;
                $display("[TB] FAIL B accept timeout: got ready low for 10 cycles required acceptance %0d", k);
            end
            accB[k] = cyc;
            qB.push_back(exp_t'{instrB[k], BASE + (32'(k) << 2), 1'b0, cyc + 1});
            @(posedge clk);
            #1;
        end
        ifB.req_valid_i = 1'b0;
        for (int k = 1; k < 4; k++) begin
            checkOutput("B accept spacing", 32'(accB[k] - accB[k-1]), 32'd2);
        end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;

        // Reset in the middle of WAIT: immediate reset values, no stale response.
        applyStimulus(BASE, 32'h0, 1'b0, 0);
        rst_n = 1'b0;
        #1;
        checkResetState("midwait");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("A ready after reset", 32'(ifA.req_ready_o), 32'd1);
        repeat (6) @(negedge clk);

        begin
            int t;
            t = 0;
            while ((qA.size() != 0 || qB.size() != 0) && t < 50) begin
                @(negedge clk);
                t++;
            end
        end
        checkOutput("A outstanding expectations", 32'(qA.size()), 32'd0);
        checkOutput("B outstanding expectations", 32'(qB.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
